// File: rtl/clk_tick_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_tick_gen_if
// Description : Bus bundle for clk_tick_gen. Carries the global count enable,
//               the channel configuration write port with its acknowledge,
//               and the free-running count / tick / square outputs.
//               master : drives en and cfg_*; observes the status and outputs
//               slave  : the tick generator itself
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_tick_gen_if #(
   parameter int WIDTH = 32,
   parameter int CH    = 4,
   parameter int DIV_W = 16,
   parameter int CH_W  = 2
);
   logic             en;       // global count enable
   logic             cfg_we;   // configuration write strobe
   logic [CH_W-1:0]  cfg_ch;   // addressed channel
   logic [DIV_W-1:0] cfg_div;  // divisor D, period D+1
   logic             cfg_mode; // 0 pulse, 1 pulse + square
   logic             cfg_on;   // channel enable
   logic             cfg_ack;  // write acknowledge, cycle after cfg_we
   logic             cfg_err;  // out-of-range channel flag, with cfg_ack
   logic [WIDTH-1:0] clk_div;  // free-running count
   logic [CH-1:0]    tick;     // per-channel wrap pulse
   logic [CH-1:0]    sq;       // per-channel square wave

   modport master (
      output en, cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_on,
      input  cfg_ack, cfg_err, clk_div, tick, sq
   );

   modport slave (
      input  en, cfg_we, cfg_ch, cfg_div, cfg_mode, cfg_on,
      output cfg_ack, cfg_err, clk_div, tick, sq
   );
endinterface
`default_nettype wire

// File: rtl/clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_tick_gen
// Description : Gated free-running counter plus CH programmable divider
//               channels. Each enabled channel counts enabled cycles and
//               wraps every D+1 of them, producing a one-cycle tick and, in
//               mode 1, a 50%-duty square wave that toggles at each wrap.
//               All outputs are registered.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - clk_tick_gen_if slave modport (en, cfg write port,
//                      cfg_ack/cfg_err, clk_div, tick, sq)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_tick_gen #(
   parameter int WIDTH = 32,
   parameter int CH    = 4,
   parameter int DIV_W = 16,
   parameter int CH_W  = 2
) (
   input  wire logic     clk,
   input  wire logic     rst,
   clk_tick_gen_if.slave bus
);

   // ------------------------------------------------------------------------
   // Free-running count: wraps naturally at 2^WIDTH
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_clk_div;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_div <= '0;
      end else if (bus.en) begin
         r_clk_div <= r_clk_div + WIDTH'(1);
      end
   end

   assign bus.clk_div = r_clk_div;

   // ------------------------------------------------------------------------
   // Channel-select range check. When CH fills the whole select space no
   // address can be out of range, so the comparison is not built at all.
   // ------------------------------------------------------------------------
   logic w_bad_ch;

   generate
      if (CH < (2 ** CH_W)) begin : g_range_chk
         assign w_bad_ch = (bus.cfg_ch >= CH_W'(CH));
      end else begin : g_range_full
         assign w_bad_ch = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Write acknowledge: every strobe is answered one cycle later, so
   // back-to-back writes give back-to-back acks.
   // ------------------------------------------------------------------------
   logic r_cfg_ack;
   logic r_cfg_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_ack <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_ack <= bus.cfg_we;
         r_cfg_err <= bus.cfg_we & w_bad_ch;
      end
   end

   assign bus.cfg_ack = r_cfg_ack;
   assign bus.cfg_err = r_cfg_err;

   // ------------------------------------------------------------------------
   // Divider channels
   // ------------------------------------------------------------------------
   logic [CH-1:0] w_tick;
   logic [CH-1:0] w_sq;

   generate
      for (genvar i = 0; i < CH; i++) begin : g_ch
         logic [DIV_W-1:0] r_div;
         logic [DIV_W-1:0] r_cnt;
         logic             r_mode;
         logic             r_on;
         logic             r_tick;
         logic             r_sq;
         logic             w_wr;
         logic             w_wrap;

         // An out-of-range address never equals a valid index, so it
         // selects no channel.
         assign w_wr   = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
         assign w_wrap = (r_cnt == r_div);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_div  <= '0;
               r_cnt  <= '0;
               r_mode <= 1'b0;
               r_on   <= 1'b0;
               r_tick <= 1'b0;
               r_sq   <= 1'b0;
            end else if (w_wr) begin
               // A write restarts the channel phase and takes precedence
               // over a wrap landing on the same edge.
               r_div  <= bus.cfg_div;
               r_mode <= bus.cfg_mode;
               r_on   <= bus.cfg_on;
               r_cnt  <= '0;
               r_tick <= 1'b0;
               r_sq   <= 1'b0;
            end else if (!r_on) begin
               r_cnt  <= '0;
               r_tick <= 1'b0;
               r_sq   <= 1'b0;
            end else if (!bus.en) begin
               // Gated: phase and square level freeze, no tick.
               r_tick <= 1'b0;
            end else if (w_wrap) begin
               r_cnt  <= '0;
               r_tick <= 1'b1;
               r_sq   <= r_mode ? ~r_sq : 1'b0;
            end else begin
               r_cnt  <= r_cnt + DIV_W'(1);
               r_tick <= 1'b0;
            end
         end

         assign w_tick[i] = r_tick;
         assign w_sq[i]   = r_sq;
      end
   endgenerate

   assign bus.tick = w_tick;
   assign bus.sq   = w_sq;

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_tick_gen
// Description : Self-checking bench for clk_tick_gen. Each driven cycle
//               pushes the predicted outputs to a scoreboard queue; they are
//               popped and compared after the edge. Directed checks against
//               fixed patterns cover the main scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_tick_gen;
   localparam int WIDTH = 4;
   localparam int CH    = 4;
   localparam int DIV_W = 16;
   localparam int CH_W  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   clk_tick_gen_if #(.WIDTH(WIDTH), .CH(CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

   clk_tick_gen #(.WIDTH(WIDTH), .CH(CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [WIDTH-1:0] cnt;
      logic [CH-1:0]    tick;
      logic [CH-1:0]    sq;
      logic             ack;
      logic             err;
   } exp_t;

   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   string phase    = "init";

   // Reference model state
   logic [WIDTH-1:0] m_cnt;
   logic [DIV_W-1:0] m_d   [CH];
   logic [DIV_W-1:0] m_c   [CH];
   logic             m_mode[CH];
   logic             m_on  [CH];
   logic             m_tick[CH];
   logic             m_sq  [CH];
   logic             m_ack;
   logic             m_err;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s/%s: got %0h expected %0h", phase, tag, act, exp);
      end
   endtask

   // Advance the model by one edge given the inputs presented before it.
   task automatic model_step(input logic r, input logic e, input logic we,
                             input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv,
                             input logic md, input logic on);
      if (r) begin
         m_cnt = '0;
         m_ack = 1'b0;
         m_err = 1'b0;
         for (int i = 0; i < CH; i++) begin
            m_d[i] = '0; m_c[i] = '0; m_mode[i] = 1'b0; m_on[i] = 1'b0;
            m_tick[i] = 1'b0; m_sq[i] = 1'b0;
         end
      end else begin
         m_ack = we;
         m_err = we && (int'(ch) >= CH);
         if (e) m_cnt = m_cnt + 1'b1;
         for (int i = 0; i < CH; i++) begin
            if (we && int'(ch) == i) begin
               m_d[i] = dv; m_mode[i] = md; m_on[i] = on;
               m_c[i] = '0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (!m_on[i]) begin
               m_c[i] = '0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (!e) begin
               m_tick[i] = 1'b0;
            end else if (m_c[i] == m_d[i]) begin
               m_c[i] = '0; m_tick[i] = 1'b1;
               m_sq[i] = m_mode[i] ? ~m_sq[i] : 1'b0;
            end else begin
               m_c[i] = m_c[i] + 1'b1; m_tick[i] = 1'b0;
            end
         end
      end
   endtask

   // One clock cycle: drive on the falling edge, predict, compare after rise.
   task automatic cyc(input logic r, input logic e, input logic we,
                      input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv,
                      input logic md, input logic on);
      exp_t x;
      exp_t want;
      @(negedge clk);
      rst          = r;
      bus.en       = e;
      bus.cfg_we   = we;
      bus.cfg_ch   = ch;
      bus.cfg_div  = dv;
      bus.cfg_mode = md;
      bus.cfg_on   = on;
      model_step(r, e, we, ch, dv, md, on);
      x.cnt = m_cnt;
      x.ack = m_ack;
      x.err = m_err;
      for (int i = 0; i < CH; i++) begin
         x.tick[i] = m_tick[i];
         x.sq[i]   = m_sq[i];
      end
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      want = sb_q.pop_front();
      chk("clk_div", 32'(bus.clk_div), 32'(want.cnt));
      chk("tick",    32'(bus.tick),    32'(want.tick));
      chk("sq",      32'(bus.sq),      32'(want.sq));
      chk("ack",     32'(bus.cfg_ack), 32'(want.ack));
      chk("err",     32'(bus.cfg_err), 32'(want.err));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv,
                     input logic md, input logic on);
      cyc(1'b0, 1'b1, 1'b1, ch, dv, md, on);
   endtask

   logic [WIDTH-1:0] cnt_hold;
   logic [CH-1:0]    sq_hold;
   logic             found;

   initial begin
      bus.en = 1'b1; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
      bus.cfg_div = '0; bus.cfg_mode = 1'b0; bus.cfg_on = 1'b0;

      // Reset with random writes in flight
      phase = "reset";
      for (int k = 0; k < 2; k++)
         cyc(1'b1, 1'b1, 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      chk("rst_cnt",  32'(bus.clk_div), 0);
      chk("rst_tick", 32'(bus.tick), 0);
      chk("rst_sq",   32'(bus.sq), 0);
      chk("rst_ack",  32'(bus.cfg_ack), 0);
      idle(1);
      chk("cnt_after_release", 32'(bus.clk_div), 1);

      // Pulse mode: ch0 D=3
      phase = "pulse";
      wr(3'd0, 16'd3, 1'b0, 1'b1);
      chk("ack", 32'(bus.cfg_ack), 1);
      for (int n = 1; n <= 12; n++) begin
         idle(1);
         chk("tick0", 32'(bus.tick[0]), 32'(n % 4 == 0));
         chk("sq0",   32'(bus.sq[0]), 0);
      end

      // Square mode: ch1 D=1 -> 0,0,1,1,...
      phase = "square";
      wr(3'd1, 16'd1, 1'b1, 1'b1);
      for (int n = 0; n < 8; n++) begin
         if (n > 0) idle(1);
         chk("sq1",   32'(bus.sq[1]),   32'((n / 2) % 2));
         chk("tick1", 32'(bus.tick[1]), 32'(n > 0 && n % 2 == 0));
      end
      // ch2 D=0 toggles every cycle
      wr(3'd2, 16'd0, 1'b1, 1'b1);
      chk("sq2_start", 32'(bus.sq[2]), 0);
      for (int n = 1; n <= 4; n++) begin
         idle(1);
         chk("sq2",   32'(bus.sq[2]), 32'(n % 2));
         chk("tick2", 32'(bus.tick[2]), 1);
      end

      // Rewrite on the exact wrap edge: write wins
      phase = "collide";
      wr(3'd0, 16'd3, 1'b0, 1'b1);
      idle(3);
      wr(3'd0, 16'd5, 1'b0, 1'b1);
      chk("tick0_on_write", 32'(bus.tick[0]), 0);
      for (int n = 1; n <= 6; n++) begin
         idle(1);
         chk("tick0", 32'(bus.tick[0]), 32'(n == 6));
      end

      // Out-of-range write: flagged, nothing changes
      phase = "badch";
      wr(3'd7, 16'd9, 1'b1, 1'b1);
      chk("ack", 32'(bus.cfg_ack), 1);
      chk("err", 32'(bus.cfg_err), 1);
      for (int n = 1; n <= 5; n++) begin
         idle(1);
         chk("tick0", 32'(bus.tick[0]), 32'(n == 5));
      end

      // Enable gating: 5 frozen cycles delay the next tick by 5
      phase = "gate";
      wr(3'd0, 16'd3, 1'b0, 1'b1);
      idle(2);
      cnt_hold = bus.clk_div;
      sq_hold  = bus.sq;
      for (int n = 0; n < 5; n++) begin
         cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
         chk("cnt_frozen", 32'(bus.clk_div), 32'(cnt_hold));
         chk("tick_quiet", 32'(bus.tick), 0);
         chk("sq_frozen",  32'(bus.sq), 32'(sq_hold));
      end
      for (int n = 1; n <= 4; n++) begin
         idle(1);
         chk("tick0", 32'(bus.tick[0]), 32'(n == 2));
      end

      // clk_div wraps 15 -> 0
      phase = "wrap";
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         idle(1);
         if (bus.clk_div == 4'hF) found = 1'b1;
      end
      chk("reach_15", 32'(found), 1);
      idle(1);
      chk("wrap_to_0", 32'(bus.clk_div), 0);

      // Disable channels
      phase = "disable";
      wr(3'd0, 16'd3, 1'b0, 1'b0);
      chk("tick0", 32'(bus.tick[0]), 0);
      chk("sq0",   32'(bus.sq[0]), 0);
      wr(3'd1, 16'd1, 1'b1, 1'b0);
      chk("sq1",   32'(bus.sq[1]), 0);
      for (int n = 0; n < 4; n++) begin
         idle(1);
         chk("tick10", 32'(bus.tick[1:0]), 0);
         chk("sq10",   32'(bus.sq[1:0]), 0);
      end

      // Back-to-back writes, each acknowledged
      phase = "b2b";
      wr(3'd3, 16'd2, 1'b1, 1'b1);
      chk("ack1", 32'(bus.cfg_ack), 1);
      wr(3'd7, 16'd1, 1'b0, 1'b1);
      chk("ack2", 32'(bus.cfg_ack), 1);
      chk("err2", 32'(bus.cfg_err), 1);
      wr(3'd2, 16'd4, 1'b0, 1'b1);
      chk("ack3", 32'(bus.cfg_ack), 1);
      chk("err3", 32'(bus.cfg_err), 0);
      idle(1);
      chk("ack_drop", 32'(bus.cfg_ack), 0);
      idle(7);

      // Reset mid-count
      phase = "rst_mid";
      cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("cnt",  32'(bus.clk_div), 0);
      chk("tick", 32'(bus.tick), 0);
      chk("sq",   32'(bus.sq), 0);
      idle(1);
      chk("cnt_resume", 32'(bus.clk_div), 1);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/clk_tick_gen.md
# clk_tick_gen

Parametrised successor to the team's free-running clock divider. It keeps a gated free-running count and adds CH independently programmable divider channels. Each channel emits a one-cycle enable tick and, optionally, a 50%-duty square output. It sits next to the board clock and feeds enable strobes to display scanning, debouncing and counter logic, so no derived clocks are needed.

## Interface
- WIDTH, 32, width of free-running count `clk_div`
- CH, 4, number of divider channels (1..16)
- DIV_W, 16, width of per-channel divisor
- CH_W, 2, width of channel select; must satisfy 2^CH_W >= CH

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global count enable; when low, every counter holds
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  CH_W  channel addressed by the write
- cfg_div  in  DIV_W  divisor D; channel period is D+1 enabled cycles
- cfg_mode  in  1  0 = pulse only, 1 = pulse + square
- cfg_on  in  1  1 = enable channel, 0 = disable channel
- cfg_ack  out  1  one-cycle acknowledge, the cycle after cfg_we
- cfg_err  out  1  one-cycle flag, with cfg_ack, when cfg_ch >= CH
- clk_div  out  WIDTH  free-running count
- tick  out  CH  per-channel one-cycle pulse at channel wrap
- sq  out  CH  per-channel square wave (mode 1 only)

## Operation
- Reset has priority over all inputs, including cfg_we. Reset values:
  - clk_div = 0, tick = 0, sq = 0, cfg_ack = 0, cfg_err = 0
  - every channel: D = 0, mode = 0, on = 0, internal count c = 0
- Free-running count:
  - If en = 1, clk_div <= clk_div + 1, modulo 2^WIDTH (wraps from all-ones to 0).
  - If en = 0, clk_div holds.
- Per-channel state: D, mode, on, and a DIV_W-bit count c.
- Disabled channel (on = 0): c = 0, tick = 0, sq = 0.
- Enabled channel with en = 1:
  - If c == D: c <= 0, tick <= 1, and if mode = 1 then sq <= ~sq.
  - Otherwise: c <= c + 1, tick <= 0.
- Enabled channel with en = 0: c and sq hold, tick <= 0.
- In mode 0, sq is held at 0.
- D = 0 gives tick = 1 on every enabled cycle, and sq toggles every cycle.
- Configuration write (cfg_we = 1, cfg_ch < CH): on the same edge, the addressed channel loads D, mode and on, and clears c, tick and sq.
  - A write applies regardless of en.
  - A write coinciding with that channel's wrap: the write wins (tick = 0, sq = 0 next cycle).
  - Other channels are unaffected.
- Out-of-range write (cfg_ch >= CH): no state changes; cfg_ack = 1 and cfg_err = 1 on the next cycle.
- cfg_we on back-to-back cycles: each write is accepted, and each produces its own ack one cycle later.
- Divisor arithmetic is unsigned. The comparison c == D is exact. Writing a new D smaller than the current c is harmless, because the write clears c.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- cfg_ack / cfg_err: high exactly in the cycle after the cfg_we edge.
- First tick after a write at edge k, with en held high: tick is high in the cycle following edge k+D+1. Subsequent ticks follow every D+1 cycles.
- tick width: exactly 1 cycle.
- sq period in mode 1: 2(D+1) enabled cycles, 50% duty. sq starts low after a write and rises at the first wrap.
- en low for N cycles stretches the tick and sq phase by exactly N cycles.
- rst asserted mid-count: all outputs read reset values in the cycle after the reset edge. Counting resumes on the first edge with rst = 0 and en = 1.

## Test plan
- Reset: drive rst for 2 cycles with random cfg_we and en high -> all outputs 0; no ack; clk_div = 0 after reset, then clk_div = 1 one cycle after release.
- Pulse mode: write ch0 D = 3, mode 0, on 1, with en = 1 -> tick[0] high once every 4 cycles, first at 4 cycles after the write; sq[0] stays 0; cfg_ack = 1 for one cycle.
- Square mode: write ch1 D = 1, mode 1 -> sq[1] = 0,0,1,1,0,0,… (period 4); tick[1] pulses at each sq edge; D = 0 gives sq toggling every cycle.
- Rewrite mid-count / collision: ch0 running D = 3, then rewrite D = 5 on the exact wrap cycle -> no tick that cycle; next tick 6 cycles later. Write ch7 with CH = 4 -> cfg_ack = 1 and cfg_err = 1; no channel changes.
- Enable gating: drop en for 5 cycles mid-period -> clk_div, c and sq frozen, tick stays 0; the following tick is delayed by exactly 5 cycles.
- Wrap and disable: WIDTH = 4 -> clk_div wraps 15 -> 0. Write ch0 with on = 0 -> tick[0] and sq[0] are 0 from the next cycle.
